mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage controller that sequences one data-memory access per CPU request over a handshaked word bus.
- Generates word-aligned address, byte enables and lane-replicated store data.
- Stalls the pipeline until the bus acknowledges, then returns the load data extracted and zero- or sign-extended.
- Detects misaligned accesses and bus timeouts and reports them as one-cycle pulses.

Parameters:
- TMO_W, 4, width of the bus-timeout counter.
- TMO_MAX, 15, cycles in BUS without bus_ack before abort (1..2^TMO_W-1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- mreq  in  1  CPU access request; held stable with all CPU inputs while stall=1
- mwr  in  1  1=store, 0=load
- mop  in  3  loads: 000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb; stores: 000 sw, 001 sh, 011 sb; other codes are invalid
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- stall  out  1  freeze pipeline
- rdata  out  32  extended load result, valid when done=1
- done  out  1  one-cycle completion pulse
- adel  out  1  misaligned or invalid load pulse
- ades  out  1  misaligned or invalid store pulse
- berr  out  1  bus-timeout pulse
- bus_req  out  1  bus request, level
- bus_we  out  1  write strobe
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  replicated store data
- bus_ack  in  1  one-cycle acknowledge from memory
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- States: IDLE, BUS, DONE. Reset → IDLE. All registered outputs reset to 0: rdata=0, done=0, adel=ades=berr=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, timeout counter=0.
- Alignment check, combinational on the current inputs:
  - Word access: misaligned if addr[1:0]≠0.
  - Half access: misaligned if addr[0]=1.
  - Byte access: never misaligned.
  - An invalid mop counts as misaligned.
- IDLE, mreq=1, misaligned:
  - Pulse adel (mwr=0) or ades (mwr=1) in the next cycle.
  - No bus transaction. stall=0 in the request cycle, so the pipeline takes the exception.
  - Stay in IDLE.
- IDLE, mreq=1, aligned:
  - stall=1 combinationally.
  - Latch addr[1:0], mop and mwr.
  - Drive the bus registers: bus_req=1, bus_we=mwr, bus_addr, bus_be, bus_wdata.
  - Clear the timeout counter and go to BUS.
- Byte enables, little-endian:
  - Word: 1111.
  - Half: 0011 if a[1]=0, 1100 if a[1]=1.
  - Byte: 0001, 0010, 0100 or 1000 for a=00, 01, 10, 11.
  - Loads drive the same enables.
- Store data:
  - sw: wdata.
  - sh: {wdata[15:0], wdata[15:0]}.
  - sb: wdata[7:0] replicated 4 times.
- BUS state:
  - stall=1, bus outputs held constant, counter increments each cycle.
  - On bus_ack: drop bus_req and bus_we. For a load, register the extracted result into rdata. Go to DONE.
  - If the counter reaches TMO_MAX without bus_ack: drop bus_req, pulse berr, set rdata=0, go to DONE.
  - bus_ack in the same cycle the counter reaches TMO_MAX: ack wins, no berr.
- Load extraction:
  - h = a[1] ? word[31:16] : word[15:0].
  - b = a[0] ? h[15:8] : h[7:0].
  - lw returns the word; lhu/lh zero/sign-extend h; lbu/lb zero/sign-extend b.
  - Stores leave rdata unchanged.
- DONE state: done=1, stall=0 (pipeline advances this cycle). Next state is IDLE.
- Back-to-back requests: a new mreq is evaluated in the IDLE cycle after DONE, giving a minimum of 3 cycles per access (IDLE→BUS→DONE).
- bus_ack while not in BUS is ignored.
- Reset in any state: return to IDLE and clear outputs immediately on that edge, abandoning any in-flight transaction; a late bus_ack is ignored.
- mreq=0 in IDLE: stall=0 and bus idle.

Test Plan:
- Load byte, sign: lb addr=0x1003; bus_rdata=0x80AA5511, ack on 2nd BUS cycle → bus_addr=0x1000, bus_be=1000, stall high 3 cycles, done pulse with rdata=0xFFFFFF80.
- Load half, zero: lhu addr=0x2002; bus_rdata=0xBEEF1234 → bus_be=1100, rdata=0x0000BEEF. Repeat as lh → 0xFFFFBEEF.
- Store half: sh addr=0x3002, wdata=0xDEADCAFE → bus_we=1, bus_be=1100, bus_wdata=0xCAFECAFE. Store byte: sb addr=0x3001, wdata=0x000000A5 → bus_be=0010, bus_wdata=0xA5A5A5A5.
- Misalignment: lw addr=0x4002 → adel pulse, bus_req never 1, stall 0. sh addr=0x4001 → ades pulse. mop=111 load → adel pulse.
- Timeout: TMO_MAX=15, lw with no bus_ack → berr pulse after 15 BUS cycles, done=1, rdata=0, bus_req low. Ack exactly at count 15 → no berr, normal done.
- Reset mid-BUS: assert rst during BUS, then ack the next cycle → bus_req=0, state IDLE, no done, no rdata update.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Purpose : MEM-stage controller; one word-bus access per CPU request, with load extraction and extension.
// Latency : minimum 3 cycles per access (IDLE -> BUS -> DONE); done/rdata are valid in the DONE cycle.
// Backpr. : stall holds the pipeline from the request cycle until bus_ack or timeout; misaligned requests never stall.
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   mreq, mwr, mop, addr,    CPU request; held stable by the CPU while stall=1
//   wdata
//   stall                    combinational pipeline freeze
//   rdata, done              extended load result and one-cycle completion pulse
//   adel, ades, berr         load/store misalignment and bus-timeout pulses
//   bus_req .. bus_wdata     registered word-bus request (level until ack/timeout)
//   bus_ack, bus_rdata       one-cycle acknowledge and read word from memory

module mem_access_ctrl #(
   parameter int TMO_W   = 4,
   parameter int TMO_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mreq,
   input  logic        mwr,
   input  logic [2:0]  mop,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        adel,
   output logic        ades,
   output logic        berr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } size_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic [1:0]       a_q;
   logic [2:0]       mop_q;
   logic             mwr_q;

   // Request decode on the live CPU inputs.
   size_t       req_size;
   logic        op_valid;
   logic        misal;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;

   always_comb begin
      req_size = SZ_WORD;
      op_valid = 1'b1;
      if (mwr) begin
         case (mop)
            3'b000:  req_size = SZ_WORD;
            3'b001:  req_size = SZ_HALF;
            3'b011:  req_size = SZ_BYTE;
            default: op_valid = 1'b0;
         endcase
      end else begin
         case (mop)
            3'b000:  req_size = SZ_WORD;
            3'b001,
            3'b010:  req_size = SZ_HALF;
            3'b011,
            3'b100:  req_size = SZ_BYTE;
            default: op_valid = 1'b0;
         endcase
      end
   end

   // An invalid opcode is reported through the same exception path as misalignment.
   always_comb begin
      misal = !op_valid;
      if (req_size == SZ_WORD && addr[1:0] != 2'b00)
         misal = 1'b1;
      if (req_size == SZ_HALF && addr[0])
         misal = 1'b1;
   end

   // Little-endian lane enables; loads use the same enables as stores.
   always_comb begin
      req_be = 4'b1111;
      case (req_size)
         SZ_HALF: req_be = addr[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: begin
            case (addr[1:0])
               2'b00:   req_be = 4'b0001;
               2'b01:   req_be = 4'b0010;
               2'b10:   req_be = 4'b0100;
               default: req_be = 4'b1000;
            endcase
         end
         default: req_be = 4'b1111;
      endcase
   end

   // Store data is replicated across all lanes so memory only needs the enables.
   always_comb begin
      case (req_size)
         SZ_HALF: req_wdata = {2{wdata[15:0]}};
         SZ_BYTE: req_wdata = {4{wdata[7:0]}};
         default: req_wdata = wdata;
      endcase
   end

   // Load extraction from the acknowledged word, using the latched offset and opcode.
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_result;

   always_comb begin
      ld_half = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      ld_byte = a_q[0] ? ld_half[15:8] : ld_half[7:0];
      case (mop_q)
         3'b001:  ld_result = {16'h0000, ld_half};
         3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
         3'b011:  ld_result = {24'h000000, ld_byte};
         3'b100:  ld_result = {{24{ld_byte[7]}}, ld_byte};
         default: ld_result = bus_rdata;
      endcase
   end

   // Stall is combinational so the pipeline freezes in the very cycle the request is seen.
   always_comb begin
      stall = 1'b0;
      if (state == S_BUS)
         stall = 1'b1;
      else if (state == S_IDLE && mreq && !misal)
         stall = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tmo_cnt   <= '0;
         a_q       <= 2'b00;
         mop_q     <= 3'b000;
         mwr_q     <= 1'b0;
         rdata     <= 32'h0;
         done      <= 1'b0;
         adel      <= 1'b0;
         ades      <= 1'b0;
         berr      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'h0;
      end else begin
         // Pulses default low; set only on the edge that enters the reporting cycle.
         done <= 1'b0;
         adel <= 1'b0;
         ades <= 1'b0;
         berr <= 1'b0;

         case (state)
            S_IDLE: begin
               if (mreq) begin
                  if (misal) begin
                     adel <= !mwr;
                     ades <= mwr;
                  end else begin
                     a_q       <= addr[1:0];
                     mop_q     <= mop;
                     mwr_q     <= mwr;
                     bus_req   <= 1'b1;
                     bus_we    <= mwr;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_be    <= req_be;
                     bus_wdata <= req_wdata;
                     tmo_cnt   <= '0;
                     state     <= S_BUS;
                  end
               end
            end

            S_BUS: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // Ack is checked first so an ack on the final allowed cycle still completes normally.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (!mwr_q)
                     rdata <= ld_result;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  berr    <= 1'b1;
                  rdata   <= 32'h0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end

            S_DONE: begin
               // The CPU inputs still show the finished request here; they are ignored.
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : self-checking bench for mem_access_ctrl with a pulse scoreboard.
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpr. : the bench holds the CPU request while stall=1 and acks on a chosen BUS cycle.

module tb_mem_access_ctrl;

   localparam int TMO_W   = 4;
   localparam int TMO_MAX = 15;

   logic        clk;
   logic        rst;
   logic        mreq;
   logic        mwr;
   logic [2:0]  mop;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        adel;
   logic        ades;
   logic        berr;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   mem_access_ctrl #(
      .TMO_W   (TMO_W),
      .TMO_MAX (TMO_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mreq      (mreq),
      .mwr       (mwr),
      .mop       (mop),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .rdata     (rdata),
      .done      (done),
      .adel      (adel),
      .ades      (ades),
      .berr      (berr),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard entry: expected {done,adel,ades,berr} and, optionally, rdata.
   typedef struct packed {
      logic [3:0]  flags;
      logic        chk_rd;
      logic [31:0] rd;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst && (done || adel || ades || berr)) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_pulse", {28'h0, done, adel, ades, berr}, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("pulse_flags", {28'h0, done, adel, ades, berr}, {28'h0, mon_e.flags});
            if (mon_e.chk_rd)
               check_eq("rdata", rdata, mon_e.rd);
         end
      end
   end

   // Aligned access: ack on BUS cycle ack_at (0 = never, forcing a timeout).
   task automatic do_access(input string nm, input logic wr, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                            input int ack_at, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic exp_berr, input logic [31:0] exp_rd);
      exp_t e;
      int   n;
      int   stalls;
      int   exp_stalls;
      logic acked;
      e.flags  = {1'b1, 1'b0, 1'b0, exp_berr};
      e.chk_rd = 1'b1;
      e.rd     = exp_rd;
      sb_q.push_back(e);
      exp_stalls = ((ack_at > 0) ? ack_at : TMO_MAX) + 1;

      mreq  = 1'b1;
      mwr   = wr;
      mop   = op;
      addr  = a;
      wdata = wd;
      @(negedge clk);
      check_eq({nm, ".req_stall"}, {31'h0, stall}, 32'h1);
      check_eq({nm, ".req_busidle"}, {31'h0, bus_req}, 32'h0);
      stalls = (stall === 1'b1) ? 1 : 0;
      n      = 0;
      acked  = 1'b0;
      while (!acked && n < TMO_MAX) begin
         @(posedge clk);
         #1;
         n++;
         acked     = (n == ack_at);
         bus_ack   = acked;
         bus_rdata = acked ? rword : ~rword;
         @(negedge clk);
         if (stall === 1'b1)
            stalls++;
         if (n == 1) begin
            check_eq({nm, ".bus_req"}, {31'h0, bus_req}, 32'h1);
            check_eq({nm, ".bus_we"}, {31'h0, bus_we}, {31'h0, wr});
            check_eq({nm, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
            check_eq({nm, ".bus_be"}, {28'h0, bus_be}, {28'h0, exp_be});
            if (wr)
               check_eq({nm, ".bus_wdata"}, bus_wdata, exp_wd);
         end
      end
      if (ack_at == 0)
         check_eq({nm, ".held_req"}, {31'h0, bus_req}, 32'h1);
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check_eq({nm, ".done_stall"}, {31'h0, stall}, 32'h0);
      check_eq({nm, ".done_busidle"}, {31'h0, bus_req}, 32'h0);
      check_eq({nm, ".stall_cycles"}, stalls, exp_stalls);
      @(posedge clk);
      #1;
      mreq = 1'b0;
   endtask

   // Misaligned or invalid access: exception pulse next cycle, no bus activity.
   task automatic do_bad(input string nm, input logic wr, input logic [2:0] op, input logic [31:0] a);
      exp_t e;
      e.flags  = {1'b0, !wr, wr, 1'b0};
      e.chk_rd = 1'b0;
      e.rd     = 32'h0;
      sb_q.push_back(e);
      mreq  = 1'b1;
      mwr   = wr;
      mop   = op;
      addr  = a;
      wdata = 32'h1234_5678;
      @(negedge clk);
      check_eq({nm, ".stall"}, {31'h0, stall}, 32'h0);
      check_eq({nm, ".busidle0"}, {31'h0, bus_req}, 32'h0);
      @(posedge clk);
      #1;
      mreq = 1'b0;
      @(negedge clk);
      check_eq({nm, ".busidle1"}, {31'h0, bus_req}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      mreq      = 1'b0;
      mwr       = 1'b0;
      mop       = 3'b000;
      addr      = 32'h0;
      wdata     = 32'h0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst.pulses", {28'h0, done, adel, ades, berr}, 32'h0);
      check_eq("rst.bus_ctl", {29'h0, bus_req, bus_we, stall}, 32'h0);
      check_eq("rst.rdata", rdata, 32'h0);
      check_eq("rst.bus_addr", bus_addr, 32'h0);
      check_eq("rst.bus_be", {28'h0, bus_be}, 32'h0);
      check_eq("rst.bus_wdata", bus_wdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      //        name   wr    op      addr          wdata         bus word      ack be       bus wdata     berr  rdata
      do_access("lb",  1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80AA_5511, 2, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80);
      do_access("lhu", 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 1, 4'b1100, 32'h0,        1'b0, 32'h0000_BEEF);
      do_access("lh",  1'b0, 3'b010, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 3, 4'b1100, 32'h0,        1'b0, 32'hFFFF_BEEF);
      do_access("sh",  1'b1, 3'b001, 32'h0000_3002, 32'hDEAD_CAFE, 32'h0,        1, 4'b1100, 32'hCAFE_CAFE, 1'b0, 32'hFFFF_BEEF);
      do_access("sb",  1'b1, 3'b011, 32'h0000_3001, 32'h0000_00A5, 32'h0,        2, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'hFFFF_BEEF);
      do_access("lw",  1'b0, 3'b000, 32'h0000_6000, 32'h0,        32'h1357_2468, 1, 4'b1111, 32'h0,        1'b0, 32'h1357_2468);
      do_access("lbu", 1'b0, 3'b011, 32'h0000_6002, 32'h0,        32'h12C3_4455, 1, 4'b0100, 32'h0,        1'b0, 32'h0000_00C3);
      do_access("sw",  1'b1, 3'b000, 32'h0000_7000, 32'hA1B2_C3D4, 32'h0,        4, 4'b1111, 32'hA1B2_C3D4, 1'b0, 32'h0000_00C3);

      do_bad("lw_mis",  1'b0, 3'b000, 32'h0000_4002);
      do_bad("sh_mis",  1'b1, 3'b001, 32'h0000_4001);
      do_bad("ld_inv",  1'b0, 3'b111, 32'h0000_4000);
      do_bad("st_inv",  1'b1, 3'b010, 32'h0000_4000);

      do_access("tmo",    1'b0, 3'b000, 32'h0000_8000, 32'h0, 32'h5555_AAAA, 0,       4'b1111, 32'h0, 1'b1, 32'h0);
      do_access("ack_15", 1'b0, 3'b000, 32'h0000_8004, 32'h0, 32'hCAFE_F00D, TMO_MAX, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);

      // Reset while in BUS, then a late ack that must be ignored.
      mreq  = 1'b1;
      mwr   = 1'b0;
      mop   = 3'b000;
      addr  = 32'h0000_5000;
      wdata = 32'h0;
      @(negedge clk);
      check_eq("rstbus.req_stall", {31'h0, stall}, 32'h1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rstbus.bus_req", {31'h0, bus_req}, 32'h1);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      mreq = 1'b0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      @(negedge clk);
      check_eq("rstbus.req_dropped", {31'h0, bus_req}, 32'h0);
      check_eq("rstbus.stall", {31'h0, stall}, 32'h0);
      check_eq("rstbus.rdata0", rdata, 32'h0);
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      @(negedge clk);
      check_eq("rstbus.no_done", {31'h0, done}, 32'h0);
      check_eq("rstbus.rdata1", rdata, 32'h0);
      check_eq("rstbus.bus_idle", {31'h0, bus_req}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);

      check_eq("sb_empty", sb_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
